window_sum_2d: RTL

- Streaming 2-D rectangular window accumulator for the stereo matching cost path.
- Generalised successor of the fixed-size square-window SHD block:
  - independent window width and height, parametrised data width;
  - frame-start alignment and per-line/per-frame border masking;
  - self-advancing valid pipeline with fixed latency.
- Sits between the per-pixel Hamming/difference stage and the disparity selector.
- Produces, per accepted raster pixel, the sum of (new − old) input differences over a WW×WH window whose bottom-right corner is that pixel.

---
 rtl/window_sum_2d.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/window_sum_2d.sv
// -----------------------------------------------------------------------------
// window_sum_2d
//   Streaming 2-D rectangular window accumulator for the stereo cost path.
//   For every accepted raster pixel (x,y) it emits the signed sum of
//   (new - old) input differences over the WW x WH window whose bottom-right
//   corner is that pixel. Fixed latency of four cycles with no stall.
//
//   Pipeline:
//     S1  register inputs, d = new - old (old masked while y < WH)
//     S2  column sum  c = colmem[x] + d  (colmem read as 0 on y = 0)
//     S3  horizontal difference  h = c - c_WW (c_WW masked while x < WW)
//     S4  running row accumulator, registered onto o_data
//
// Parameters:
//   DW  input sample width (unsigned)
//   WW  window width in pixels  (>= 2)
//   WH  window height in lines  (>= 2)
//   M   pixels per line         (> WW)
//   OW  output width, derived, not overridable
//
// Ports:
//   i_clk       clock, rising edge
//   i_rstn      synchronous active-low reset
//   i_dval      input sample valid, one raster pixel per cycle
//   i_sof       start of frame, qualified by i_dval, forces (x,y) = (0,0)
//   i_data_new  sample entering the window
//   i_data_old  sample leaving the window (same column, WH lines earlier)
//   o_dval      o_data holds a complete-window sum
//   o_eol       o_dval pixel is the last of its line
//   o_data      signed window sum
//
// Build option:
//   WINDOW_SUM_CLAMP_EN  when defined, negative sums are presented as 0 on
//                        o_data; the internal accumulator keeps its true value.
// -----------------------------------------------------------------------------
module window_sum_2d #(
  parameter  int unsigned DW = 5,
  parameter  int unsigned WW = 7,
  parameter  int unsigned WH = 13,
  parameter  int unsigned M  = 650,
  localparam int unsigned OW = DW + $clog2(WW * WH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_dval,
  input  logic                 i_sof,
  input  logic [DW-1:0]        i_data_new,
  input  logic [DW-1:0]        i_data_old,
  output logic                 o_dval,
  output logic                 o_eol,
  output logic signed [OW-1:0] o_data
);

  localparam int unsigned XW = $clog2(M);
  localparam int unsigned YW = $clog2(WH + 1);
  localparam int unsigned EW = OW - DW - 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XW-1:0]          x_q,      x_d;
  logic [YW-1:0]          y_q,      y_d;

  logic                   s1_v_q,   s1_v_d;
  logic [XW-1:0]          s1_x_q,   s1_x_d;
  logic [YW-1:0]          s1_y_q,   s1_y_d;
  logic [DW:0]            s1_d_q,   s1_d_d;

  logic                   s2_v_q,   s2_v_d;
  logic [XW-1:0]          s2_x_q,   s2_x_d;
  logic [YW-1:0]          s2_y_q,   s2_y_d;
  logic [OW-1:0]          s2_c_q,   s2_c_d;

  logic                   s3_v_q,   s3_v_d;
  logic [XW-1:0]          s3_x_q,   s3_x_d;
  logic [YW-1:0]          s3_y_q,   s3_y_d;
  logic [OW-1:0]          s3_h_q,   s3_h_d;

  logic [WW-1:0][OW-1:0]  sr_q,     sr_d;
  logic [OW-1:0]          acc_q,    acc_d;

  logic                   o_dval_q, o_dval_d;
  logic                   o_eol_q,  o_eol_d;
  logic [OW-1:0]          o_data_q, o_data_d;

  // Column sums; not reset, masked by y = 0 on the first line of a frame.
  logic [OW-1:0]          colmem_q [M];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [XW-1:0]          tag_x;
  logic [YW-1:0]          tag_y;
  logic [DW-1:0]          old_m;
  logic [OW-1:0]          col_rd;
  logic [OW-1:0]          d_ext;
  logic [OW-1:0]          c_ww;

  // Raster position of the sample on the inputs; i_sof overrides the counters.
  always_comb begin
    tag_x = x_q;
    tag_y = y_q;
    if (i_sof) begin
      tag_x = '0;
      tag_y = '0;
    end
  end

  // Position counters: x wraps at M-1, y saturates at WH.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_dval) begin
      if (tag_x == XW'(M - 1)) begin
        x_d = '0;
        y_d = (tag_y == YW'(WH)) ? tag_y : tag_y + YW'(1);
      end else begin
        x_d = tag_x + XW'(1);
        y_d = tag_y;
      end
    end
  end

  // S1: zero-extend and subtract; the leaving sample does not exist yet
  // while fewer than WH lines have been seen.
  always_comb begin
    old_m  = (tag_y < YW'(WH)) ? '0 : i_data_old;
    s1_v_d = i_dval;
    s1_x_d = tag_x;
    s1_y_d = tag_y;
    s1_d_d = {1'b0, i_data_new} - {1'b0, old_m};
  end

  // S2: vertical accumulation into the column memory.
  always_comb begin
    col_rd = (s1_y_q == '0) ? '0 : colmem_q[s1_x_q];
    d_ext  = {{EW{s1_d_q[DW]}}, s1_d_q};
    s2_v_d = s1_v_q;
    s2_x_d = s1_x_q;
    s2_y_d = s1_y_q;
    s2_c_d = col_rd + d_ext;
  end

  // S3: subtract the column that leaves the window on the left. The shift
  // register only advances on valid samples so bubbles do not disturb it.
  always_comb begin
    c_ww   = (s2_x_q < XW'(WW)) ? '0 : sr_q[WW-1];
    s3_v_d = s2_v_q;
    s3_x_d = s2_x_q;
    s3_y_d = s2_y_q;
    s3_h_d = s2_c_q - c_ww;
    sr_d   = sr_q;
    if (s2_v_q) begin
      sr_d = {sr_q[WW-2:0], s2_c_q};
    end
  end

  // S4: running row sum restarted at x = 0; outputs hold across bubbles.
  always_comb begin
    acc_d    = acc_q;
    o_data_d = o_data_q;
    o_dval_d = 1'b0;
    o_eol_d  = 1'b0;
    if (s3_v_q) begin
      acc_d = (s3_x_q == '0) ? s3_h_q : acc_q + s3_h_q;
`ifdef WINDOW_SUM_CLAMP_EN
      o_data_d = acc_d[OW-1] ? '0 : acc_d;
`else
      o_data_d = acc_d;
`endif
      o_dval_d = (s3_x_q >= XW'(WW - 1)) && (s3_y_q >= YW'(WH - 1));
      o_eol_d  = o_dval_d && (s3_x_q == XW'(M - 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      x_q      <= '0;
      y_q      <= '0;
      s1_v_q   <= 1'b0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      s1_d_q   <= '0;
      s2_v_q   <= 1'b0;
      s2_x_q   <= '0;
      s2_y_q   <= '0;
      s2_c_q   <= '0;
      s3_v_q   <= 1'b0;
      s3_x_q   <= '0;
      s3_y_q   <= '0;
      s3_h_q   <= '0;
      sr_q     <= '0;
      acc_q    <= '0;
      o_dval_q <= 1'b0;
      o_eol_q  <= 1'b0;
      o_data_q <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      s1_v_q   <= s1_v_d;
      s1_x_q   <= s1_x_d;
      s1_y_q   <= s1_y_d;
      s1_d_q   <= s1_d_d;
      s2_v_q   <= s2_v_d;
      s2_x_q   <= s2_x_d;
      s2_y_q   <= s2_y_d;
      s2_c_q   <= s2_c_d;
      s3_v_q   <= s3_v_d;
      s3_x_q   <= s3_x_d;
      s3_y_q   <= s3_y_d;
      s3_h_q   <= s3_h_d;
      sr_q     <= sr_d;
      acc_q    <= acc_d;
      o_dval_q <= o_dval_d;
      o_eol_q  <= o_eol_d;
      o_data_q <= o_data_d;
    end
  end

  // Column write-back; a later sample of the same column is at least M-1
  // cycles away, so no read/write forwarding is needed.
  always_ff @(posedge i_clk) begin
    if (s1_v_q) begin
      colmem_q[s1_x_q] <= s2_c_d;
    end
  end

  assign o_dval = o_dval_q;
  assign o_eol  = o_eol_q;
  assign o_data = o_data_q;

endmodule
